ext_gpio_timer: RTL and testbench
=================================

// Module: ext_gpio_timer
// PURPOSE
//  Responder on the CPU EXT bus (en/wea/addr/din/dout). Decodes word addresses into LED,
//  switch, button, sticky edge, cycle-counter and down-timer registers; returns read data
//  one cycle after the access. Sits in FPGA_TOP between the RISC-V core EXT port and board I/O.
// PARAMETERS
//  AWIDTH     16  EXT word-address width
//  NLED        4  LED outputs driven from LED register bits [NLED-1:0]
//  NIN         4  switch inputs, and separately button inputs
// PORTS
//  clk        in   1       CPU clock; all state on posedge
//  rst_n      in   1       asynchronous, active-low reset
//  ext_en     in   1       access strobe from core
//  ext_wea    in   4       byte write enables; any bit set with ext_en = write
//  ext_addr   in   AWIDTH  word address
//  ext_din    in   32      write data
//  ext_dout   out  32      read data, valid cycle after ext_en
//  switches   in   NIN     raw async board switches
//  buttons    in   NIN     raw async board buttons
//  leds       out  NLED    LED register bits
//  irq        out  1      TIMER_STAT.expired & TIMER_CTRL.irq_en
// BEHAVIOUR
//  Reset: every register, counter, synchronizer flop = 0; ext_dout=0, leds=0, irq=0.
//  Map: 0 LED RW[NLED-1:0] | 1 SW RO | 2 BTN RO | 3 BTN_EDGE W1C | 4 CYCLE RO 32b |
//   5 TIMER_LOAD RW 32b | 6 TIMER_CTRL RW [0]en [1]autoreload [2]irq_en | 7 TIMER_STAT W1C [0]expired
//  Unmapped: read 0, write ignored. Unimplemented bits read 0.
//  Write: edge where ext_en & |ext_wea; only lanes with wea[i]=1 update byte i.
//   W1C regs clear bits where written byte lane carries a 1.
//  Read: edge with ext_en=1 latches addr; ext_dout = value at that edge, from cycle N+1.
//   Held until next ext_en. Write-and-read same addr returns pre-write value.
//  Inputs: two-flop synchronizer per bit. SW/BTN read the synchronized value,
//   2 edges after a pin change.
//  BTN_EDGE[i] set on synchronized 0->1 of buttons[i]. Set same cycle as W1C: set wins.
//  CYCLE: +1 every cycle from reset, wraps 0xFFFF_FFFF->0, not writable.
//  Timer count register (internal, 32b):
//   - load from TIMER_LOAD when en written 0->1, or on a TIMER_LOAD write while en=1.
//   - en=1, count!=0: count-1 per cycle.
//   - en=1, count==0: set expired.
//     autoreload=1: count<=TIMER_LOAD.
//     autoreload=0: hardware clears en; count holds 0.
//   - LOAD=0 with autoreload: expired reasserts every cycle.
//   - expire same cycle as expired W1C: expired stays 1.
//   - en=0: count frozen.
//  irq: combinational from the two register bits; no extra latency.
//  Async reset mid-access or mid-count: all returns to reset values at once. First access
//   after rst_n rises is honoured normally.
// STRUCTURE
//  ext_regs_pkg: address constants (ADDR_LED..ADDR_TIMER_STAT), CTRL/STAT bit indices.
//  Sub-module sync_2ff (param WIDTH, clk, rst_n, d, q) instanced for switches and buttons.
//  Top level: decode, byte-lane writes, read-data register, edge detect, counters.
// TESTING
//  Write 0xA, wea=4'b0001, to addr 0; read addr 0 -> leds=4'hA, ext_dout=0xA next cycle.
//  Same write, wea=4'b0010 -> leds unchanged.
//  buttons[2] 0->1 -> BTN_EDGE=0x4 within 3 cycles; write 0x4 to addr 3 -> reads 0.
//   Pulse coinciding with clear -> reads 0x4.
//  LOAD=5, CTRL=0b001 -> expired set 6 cycles after the en write edge; en self-clears;
//   irq stays 0.
//  LOAD=2, CTRL=0b111 -> expired and irq=1 after 3 cycles, count reloads to 2.
//   W1C expired while running -> re-sets every 3 cycles.
//  Read CYCLE twice, 10 cycles apart -> difference 10.
//   Force counter to 0xFFFF_FFFE (bench backdoor) -> wraps to 0.
//  Assert rst_n=0 mid-count with LED=0xF -> immediately leds=0, irq=0, ext_dout=0, CYCLE=0.
//   Read of addr 0x9 -> 0.

Source files
------------

// File: rtl/ext_regs_pkg.sv
// ext_regs_pkg: register map, control/status bit positions and byte-lane helper
package ext_regs_pkg;
  typedef enum logic [2:0] {
    ADDR_LED, ADDR_SW, ADDR_BTN, ADDR_BTN_EDGE,
    ADDR_CYCLE, ADDR_TIMER_LOAD, ADDR_TIMER_CTRL, ADDR_TIMER_STAT
  } reg_addr_e;
  localparam int CTRL_EN = 0;
  localparam int CTRL_AR = 1;
  localparam int CTRL_IRQ = 2;
  localparam int STAT_EXP = 0;
  function automatic logic [31:0] lane_mask(input logic [3:0] wea);
    return {{8{wea[3]}}, {8{wea[2]}}, {8{wea[1]}}, {8{wea[0]}}};
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for asynchronous board inputs
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] s1;
  // first stage may go metastable; second stage gives a settled copy
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {q, s1} <= '0;
    else {q, s1} <= {s1, d};
endmodule

// File: rtl/ext_gpio_timer.sv
// ext_gpio_timer: EXT-bus GPIO, sticky button edges, cycle counter and down-timer
module ext_gpio_timer
  import ext_regs_pkg::*;
#(
  parameter int AWIDTH = 16,
  parameter int NLED = 4,
  parameter int NIN = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ext_en,
  input  logic [3:0]        ext_wea,
  input  logic [AWIDTH-1:0] ext_addr,
  input  logic [31:0]       ext_din,
  output logic [31:0]       ext_dout,
  input  logic [NIN-1:0]    switches,
  input  logic [NIN-1:0]    buttons,
  output logic [NLED-1:0]   leds,
  output logic              irq
);
  logic [NIN-1:0] sw_s, btn_s, btn_prev, btn_edge;
  logic [31:0] mask, cycle_cnt, load, count, rdata, new_load;
  logic [7:0] wsel;
  logic [2:0] ctrl, new_ctrl;
  logic expired, hit, at_zero, edge_clr, exp_clr;
  reg_addr_e idx;

  sync_2ff #(.WIDTH(NIN)) u_sw (.clk(clk), .rst_n(rst_n), .d(switches), .q(sw_s));
  sync_2ff #(.WIDTH(NIN)) u_btn (.clk(clk), .rst_n(rst_n), .d(buttons), .q(btn_s));

  assign hit = ~|ext_addr[AWIDTH-1:3];
  assign idx = reg_addr_e'(ext_addr[2:0]);
  assign mask = lane_mask(ext_wea);
  assign wsel = (ext_en && |ext_wea && hit) ? 8'b1 << idx : 8'b0;
  assign new_load = (load & ~mask) | (ext_din & mask);
  assign new_ctrl = wsel[ADDR_TIMER_CTRL] ? (ctrl & ~mask[2:0]) | (ext_din[2:0] & mask[2:0]) : ctrl;
  assign at_zero = ctrl[CTRL_EN] && count == '0;
  assign edge_clr = wsel[ADDR_BTN_EDGE];
  assign exp_clr = wsel[ADDR_TIMER_STAT] & mask[STAT_EXP] & ext_din[STAT_EXP];
  assign irq = expired & ctrl[CTRL_IRQ];

  // read mux; unmapped words and unimplemented bits return zero
  always_comb begin
    rdata = '0;
    if (hit)
      case (idx)
        ADDR_LED:        rdata = 32'(leds);
        ADDR_SW:         rdata = 32'(sw_s);
        ADDR_BTN:        rdata = 32'(btn_s);
        ADDR_BTN_EDGE:   rdata = 32'(btn_edge);
        ADDR_CYCLE:      rdata = cycle_cnt;
        ADDR_TIMER_LOAD: rdata = load;
        ADDR_TIMER_CTRL: rdata = 32'(ctrl);
        default:         rdata = 32'(expired);
      endcase
  end

  // read data captures pre-write state at the access edge and holds until the next access
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ext_dout <= '0;
    else if (ext_en) ext_dout <= rdata;

  // GPIO registers, free-running cycle counter and sticky edges (a new edge beats a clear)
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      leds <= '0;
      cycle_cnt <= '0;
      btn_prev <= '0;
      btn_edge <= '0;
    end else begin
      if (wsel[ADDR_LED]) leds <= (leds & ~mask[NLED-1:0]) | (ext_din[NLED-1:0] & mask[NLED-1:0]);
      cycle_cnt <= cycle_cnt + 32'd1;
      btn_prev <= btn_s;
      btn_edge <= (btn_edge & ~(edge_clr ? ext_din[NIN-1:0] & mask[NIN-1:0] : '0)) | (btn_s & ~btn_prev);
    end

  // down-timer: reload on enable or load update, expire at zero, one-shot clears enable
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      load <= '0;
      ctrl <= '0;
      count <= '0;
      expired <= 1'b0;
    end else begin
      if (wsel[ADDR_TIMER_LOAD]) load <= new_load;
      if (wsel[ADDR_TIMER_CTRL]) ctrl <= new_ctrl;
      else if (at_zero && !ctrl[CTRL_AR]) ctrl[CTRL_EN] <= 1'b0;
      if (wsel[ADDR_TIMER_CTRL] && new_ctrl[CTRL_EN] && !ctrl[CTRL_EN]) count <= load;
      else if (wsel[ADDR_TIMER_LOAD] && ctrl[CTRL_EN]) count <= new_load;
      else if (ctrl[CTRL_EN]) count <= at_zero ? (ctrl[CTRL_AR] ? load : count) : count - 32'd1;
      expired <= at_zero | (expired & ~exp_clr);
    end
endmodule

// File: tb/tb_ext_gpio_timer.sv
// tb_ext_gpio_timer: directed register vectors plus timer, edge, counter and reset sequences
module tb_ext_gpio_timer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ext_en = 1'b0;
  logic [3:0] ext_wea = '0;
  logic [15:0] ext_addr = '0;
  logic [31:0] ext_din = '0;
  logic [31:0] ext_dout;
  logic [3:0] switches = 4'h5;
  logic [3:0] buttons = '0;
  logic [3:0] leds;
  logic irq;
  int checks = 0;
  int failures = 0;

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  wea;
    logic [31:0] exp;
  } vec_t;
  vec_t v[18];

  ext_gpio_timer dut (
    .clk(clk), .rst_n(rst_n), .ext_en(ext_en), .ext_wea(ext_wea), .ext_addr(ext_addr),
    .ext_din(ext_din), .ext_dout(ext_dout), .switches(switches), .buttons(buttons),
    .leds(leds), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] we);
    ext_en = 1'b1; ext_addr = a; ext_din = d; ext_wea = we;
    @(negedge clk);
    ext_en = 1'b0; ext_wea = '0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [31:0] d);
    ext_en = 1'b1; ext_addr = a; ext_wea = '0;
    @(negedge clk);
    ext_en = 1'b0;
    d = ext_dout;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [31:0] r, r1;
    v[0]  = '{1, 16'd0, 32'h0000_000A, 4'b0001, 32'h0};
    v[1]  = '{0, 16'd0, 32'h0, 4'b0000, 32'h0000_000A};
    v[2]  = '{1, 16'd0, 32'h0000_0005, 4'b0010, 32'h0};
    v[3]  = '{0, 16'd0, 32'h0, 4'b0000, 32'h0000_000A};
    v[4]  = '{1, 16'd0, 32'hFFFF_FFF3, 4'b1111, 32'h0};
    v[5]  = '{0, 16'd0, 32'h0, 4'b0000, 32'h0000_0003};
    v[6]  = '{0, 16'd1, 32'h0, 4'b0000, 32'h0000_0005};
    v[7]  = '{0, 16'd2, 32'h0, 4'b0000, 32'h0000_0000};
    v[8]  = '{1, 16'd5, 32'h1234_5678, 4'b0101, 32'h0};
    v[9]  = '{0, 16'd5, 32'h0, 4'b0000, 32'h0034_0078};
    v[10] = '{1, 16'd5, 32'hAABB_CCDD, 4'b1010, 32'h0};
    v[11] = '{0, 16'd5, 32'h0, 4'b0000, 32'hAA34_CC78};
    v[12] = '{1, 16'd6, 32'hFFFF_FFFE, 4'b0001, 32'h0};
    v[13] = '{0, 16'd6, 32'h0, 4'b0000, 32'h0000_0006};
    v[14] = '{1, 16'd9, 32'hFFFF_FFFF, 4'b1111, 32'h0};
    v[15] = '{0, 16'd9, 32'h0, 4'b0000, 32'h0000_0000};
    v[16] = '{0, 16'd7, 32'h0, 4'b0000, 32'h0000_0000};
    v[17] = '{1, 16'd6, 32'h0000_0000, 4'b0001, 32'h0};
    cyc(2);
    chk("reset_leds", 32'(leds), 32'h0);
    chk("reset_irq", 32'(irq), 32'h0);
    chk("reset_dout", ext_dout, 32'h0);
    rst_n = 1'b1;
    cyc(3);
    for (int i = 0; i < 18; i++) begin
      if (v[i].wr) wr(v[i].addr, v[i].data, v[i].wea);
      else begin
        rd(v[i].addr, r);
        chk($sformatf("vec%0d_addr%0d", i, v[i].addr), r, v[i].exp);
      end
    end
    wr(16'd0, 32'hA, 4'b0001);
    chk("leds_A", 32'(leds), 32'hA);
    wr(16'd0, 32'h5, 4'b0001);
    chk("write_read_prewrite", ext_dout, 32'hA);
    wr(16'd0, 32'hA, 4'b0010);
    chk("leds_lane_masked", 32'(leds), 32'h5);
    buttons[2] = 1'b1;
    cyc(3);
    rd(16'd3, r);
    chk("btn_edge_set", r, 32'h4);
    rd(16'd2, r);
    chk("btn_level", r, 32'h4);
    wr(16'd3, 32'h4, 4'b0001);
    rd(16'd3, r);
    chk("btn_edge_clear", r, 32'h0);
    buttons[2] = 1'b0;
    cyc(4);
    buttons[2] = 1'b1;
    cyc(2);
    wr(16'd3, 32'h4, 4'b0001);
    rd(16'd3, r);
    chk("btn_edge_set_wins", r, 32'h4);
    wr(16'd5, 32'd5, 4'b1111);
    wr(16'd6, 32'b001, 4'b0001);
    ext_en = 1'b1; ext_addr = 16'd7;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      chk($sformatf("oneshot_stat_k%0d", k), ext_dout, (k == 7) ? 32'h1 : 32'h0);
    end
    ext_en = 1'b0;
    rd(16'd6, r);
    chk("oneshot_en_cleared", r, 32'h0);
    chk("oneshot_irq_low", 32'(irq), 32'h0);
    wr(16'd7, 32'h1, 4'b0001);
    rd(16'd7, r);
    chk("stat_w1c", r, 32'h0);
    wr(16'd5, 32'd2, 4'b1111);
    wr(16'd6, 32'b111, 4'b0001);
    for (int k = 1; k <= 3; k++) begin
      cyc(1);
      chk($sformatf("auto_irq_k%0d", k), 32'(irq), (k == 3) ? 32'h1 : 32'h0);
    end
    wr(16'd7, 32'h1, 4'b0001);
    chk("auto_irq_cleared", 32'(irq), 32'h0);
    cyc(1);
    chk("auto_irq_k5", 32'(irq), 32'h0);
    cyc(1);
    chk("auto_irq_reload", 32'(irq), 32'h1);
    cyc(2);
    wr(16'd7, 32'h1, 4'b0001);
    chk("expire_beats_w1c", 32'(irq), 32'h1);
    wr(16'd6, 32'h0, 4'b0001);
    wr(16'd7, 32'h1, 4'b0001);
    rd(16'd4, r1);
    cyc(9);
    rd(16'd4, r);
    chk("cycle_delta", r - r1, 32'd10);
    force dut.cycle_cnt = 32'hFFFF_FFFE;
    #1 release dut.cycle_cnt;
    ext_en = 1'b1; ext_addr = 16'd4;
    @(negedge clk);
    chk("cycle_fffe", ext_dout, 32'hFFFF_FFFE);
    @(negedge clk);
    chk("cycle_ffff", ext_dout, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("cycle_wrap", ext_dout, 32'h0);
    ext_en = 1'b0;
    wr(16'd0, 32'hF, 4'b0001);
    wr(16'd5, 32'd0, 4'b1111);
    wr(16'd6, 32'b111, 4'b0001);
    cyc(2);
    rd(16'd0, r);
    chk("pre_reset_led", r, 32'hF);
    chk("pre_reset_irq", 32'(irq), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_leds", 32'(leds), 32'h0);
    chk("async_rst_irq", 32'(irq), 32'h0);
    chk("async_rst_dout", ext_dout, 32'h0);
    cyc(2);
    rst_n = 1'b1;
    rd(16'd4, r);
    chk("post_reset_cycle", r, 32'h0);
    rd(16'd6, r);
    chk("post_reset_ctrl", r, 32'h0);
    rd(16'd9, r);
    chk("unmapped_read", r, 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
